// File: rtl/counter_bank_pkg.sv
// Shared command encodings and FSM state type for the counter bank.
// Imported by the top and its testbench-visible interface logic.
package counter_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_INC     = 2'b01,
        OP_DEC     = 2'b10,
        OP_CLR_ALL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PEND  = 2'b01,
        ST_SWEEP = 2'b10
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high while the counter is all ones (every cycle when DIV_LOG2=0).
// No latency beyond the counter itself; no backpressure.
module tick_gen #(
    parameter int DIV_LOG2 = 6
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // With no division the 1-bit counter still runs but the tick is forced high.
    assign tick = (DIV_LOG2 == 0) || (&r_cnt);

endmodule

// File: rtl/counter_bank.sv
// Register bank with two registered read ports and a tick-paced LOAD/INC/DEC/CLR_ALL command port.
// Reads: 1-cycle latency; commands: one at a time, ready low while pending or sweeping, done/ovf pulse after.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 3,
    parameter int DIV_LOG2 = 6,
    parameter int SAT      = 0,
    parameter int RST_VAL  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_ADDR-1:0] addrR0,
    input  logic [BIT_ADDR-1:0] addrR1,
    output logic [BIT_DATO-1:0] datOutR0,
    output logic [BIT_DATO-1:0] datOutR1,
    input  logic                we,
    input  logic [1:0]          op,
    input  logic [BIT_ADDR-1:0] addrW,
    input  logic [BIT_DATO-1:0] datIn,
    output logic                ready,
    output logic                done,
    output logic                ovf
);

    localparam int                  NREG     = 2 ** BIT_ADDR;
    localparam logic [BIT_DATO-1:0] RST_DAT  = BIT_DATO'(RST_VAL);
    localparam logic [BIT_DATO-1:0] MAX_DAT  = '1;
    localparam logic [BIT_DATO-1:0] ONE_DAT  = BIT_DATO'(1);
    localparam logic [BIT_ADDR-1:0] LAST_IDX = BIT_ADDR'(NREG - 1);

    logic [BIT_DATO-1:0] r_mem [NREG];
    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    logic [BIT_ADDR-1:0] r_addr;
    logic [BIT_ADDR-1:0] r_idx;
    logic [BIT_DATO-1:0] r_dat;
    logic [BIT_DATO-1:0] r_dout0;
    logic [BIT_DATO-1:0] r_dout1;
    logic                r_live;
    logic                r_done;
    logic                r_ovf;

    logic                w_tick;
    logic                w_accept;
    logic                w_is_clr;
    logic                w_apply;
    logic                w_sweep_wr;
    logic                w_last;
    logic                w_wrap;
    logic [BIT_DATO-1:0] w_cur;
    logic [BIT_DATO-1:0] w_new;

    tick_gen #(
        .DIV_LOG2(DIV_LOG2)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    assign w_accept = we && ready;
    assign w_is_clr = (op_t'(op) == OP_CLR_ALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_is_clr ? ST_SWEEP : ST_PEND;
            ST_PEND:  if (w_tick) w_state_nxt = ST_IDLE;
            ST_SWEEP: if (w_tick && (r_idx == LAST_IDX)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // r_live keeps ready low until the first edge after reset release.
    always_comb begin
        ready      = r_live && (r_state == ST_IDLE);
        w_apply    = (r_state == ST_PEND) && w_tick;
        w_sweep_wr = (r_state == ST_SWEEP) && w_tick;
        w_last     = w_sweep_wr && (r_idx == LAST_IDX);
    end

    always_comb begin
        w_cur  = r_mem[r_addr];
        w_new  = w_cur;
        w_wrap = 1'b0;
        case (r_op)
            OP_LOAD: w_new = r_dat;
            OP_INC: begin
                w_wrap = (w_cur == MAX_DAT);
                if (!w_wrap) begin
                    w_new = w_cur + ONE_DAT;
                end else if (SAT == 0) begin
                    w_new = '0;
                end
            end
            OP_DEC: begin
                w_wrap = (w_cur == '0);
                if (!w_wrap) begin
                    w_new = w_cur - ONE_DAT;
                end else if (SAT == 0) begin
                    w_new = MAX_DAT;
                end
            end
            default: w_new = w_cur;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_LOAD;
            r_addr <= '0;
            r_dat  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            if (w_is_clr) begin
                r_idx <= '0;
            end else begin
                r_op   <= op_t'(op);
                r_addr <= addrW;
                r_dat  <= datIn;
            end
        end else if (w_sweep_wr) begin
            r_idx <= r_idx + BIT_ADDR'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= RST_DAT;
            end
        end else if (w_apply) begin
            r_mem[r_addr] <= w_new;
        end else if (w_sweep_wr) begin
            r_mem[r_idx] <= RST_DAT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout0 <= RST_DAT;
            r_dout1 <= RST_DAT;
            r_live  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_dout0 <= r_mem[addrR0];
            r_dout1 <= r_mem[addrR1];
            r_live  <= 1'b1;
            r_done  <= w_apply || w_last;
            r_ovf   <= w_apply && w_wrap;
        end
    end

    assign datOutR0 = r_dout0;
    assign datOutR1 = r_dout1;
    assign done     = r_done;
    assign ovf      = r_ovf;

endmodule
